// File: rtl/camera_i2c_arbiter_if.sv
// ---------------------------------------------------------------------------
// camera_i2c_arbiter_if
// Bundles the two requester handshakes and the I2C write-engine handshake
// of the camera register arbiter.
//
//   req0/req1       request, held high with dataN stable until doneN
//   data0/data1     {sub_addr[7:0], value[15:0]}
//   done0/done1     one-cycle completion pulse to the granted requester
//   err0/err1       valid with doneN, 1 = NACK after retries or timeout
//   busy            arbiter is not idle
//   eng_data        {slave address, latched word} presented to the engine
//   eng_go          start level to the engine, held until eng_end
//   eng_end         engine transfer complete (level or pulse)
//   eng_nack        sampled with eng_end, 1 = slave did not acknowledge
//   timeout_flag    sticky abort indicator
//
// slave modport:  the arbiter side.
// master modport: the surrounding system (requesters plus engine).
// ---------------------------------------------------------------------------
interface camera_i2c_arbiter_if;
  logic        req0;
  logic [23:0] data0;
  logic        done0;
  logic        err0;
  logic        req1;
  logic [23:0] data1;
  logic        done1;
  logic        err1;
  logic        busy;
  logic [31:0] eng_data;
  logic        eng_go;
  logic        eng_end;
  logic        eng_nack;
  logic        timeout_flag;

  modport slave (
    input  req0, data0, req1, data1, eng_end, eng_nack,
    output done0, err0, done1, err1, busy, eng_data, eng_go, timeout_flag
  );

  modport master (
    output req0, data0, req1, data1, eng_end, eng_nack,
    input  done0, err0, done1, err1, busy, eng_data, eng_go, timeout_flag
  );
endinterface

// File: rtl/camera_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// camera_i2c_arbiter
// Shares one I2C register-write engine between the boot-time configuration
// sequencer (requester 0) and the runtime register updater (requester 1).
// Grants round-robin, frames the 24-bit word with the sensor write address,
// re-issues NACKed transfers up to MAX_RETRY times, aborts a transfer that
// sees no eng_end within TIMEOUT_CYCLES, and pulses done/err to the owner.
//
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      camera_i2c_arbiter_if.slave (requester and engine handshakes)
// ---------------------------------------------------------------------------
module camera_i2c_arbiter #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'hBA,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned TO_W           = 24
) (
  input  logic                 clock,
  input  logic                 reset_n,
  camera_i2c_arbiter_if.slave  bus
);

  localparam int unsigned     RC_W        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RETRY_LIMIT = RC_W'(MAX_RETRY);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    DONE,
    REL
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            owner;
  logic            last;
  logic            result;
  logic [23:0]     word;
  logic [RC_W-1:0] retry_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            any_req;
  logic            grant_owner;
  logic            timed_out;
  logic            can_retry;

  // On a tie the requester that did not win last time gets the engine.
  assign any_req     = bus.req0 | bus.req1;
  assign grant_owner = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign timed_out   = (to_cnt == TO_LAST);
  assign can_retry   = (retry_cnt < RETRY_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // eng_end is checked before the timeout so a completion that lands on the
  // last allowed cycle still reports its real ack/nack result.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (any_req) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (bus.eng_end) begin
          if (bus.eng_nack && can_retry) next_state = GAP;
          else                           next_state = DONE;
        end else if (timed_out) begin
          next_state = DONE;
        end
      end
      // Wait for a level-style eng_end to fall so the re-issue is a clean edge.
      GAP:   if (!bus.eng_end) next_state = ISSUE;
      DONE:  next_state = REL;
      REL:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // eng_go is exactly the WAIT state: raised on ISSUE->WAIT, dropped on every exit.
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.eng_go = (state == WAIT);
    bus.done0  = 1'b0;
    bus.err0   = 1'b0;
    bus.done1  = 1'b0;
    bus.err1   = 1'b0;
    if (state == DONE) begin
      bus.done0 = ~owner;
      bus.err0  = ~owner & result;
      bus.done1 = owner;
      bus.err1  = owner & result;
    end
  end

  // Grant bookkeeping, engine word, retry/timeout counters and result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner            <= 1'b0;
      last             <= 1'b1;
      word             <= '0;
      retry_cnt        <= '0;
      to_cnt           <= '0;
      result           <= 1'b0;
      bus.eng_data     <= '0;
      bus.timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_owner;
            last      <= grant_owner;
            word      <= grant_owner ? bus.data1 : bus.data0;
            retry_cnt <= '0;
          end
        end
        ISSUE: begin
          bus.eng_data <= {SLAVE_ADDR, word};
          to_cnt       <= '0;
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus.eng_end) begin
            if (!bus.eng_nack)  result    <= 1'b0;
            else if (can_retry) retry_cnt <= retry_cnt + 1'b1;
            else                result    <= 1'b1;
          end else if (timed_out) begin
            result           <= 1'b1;
            bus.timeout_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_camera_i2c_arbiter
// Drives the two requesters and a behavioural I2C engine, and compares what
// the arbiter does against a transaction-level model: which requester is
// served in which order, how many GO edges each transfer needs, the framed
// engine word, err/done results, latencies and the sticky timeout flag.
// ---------------------------------------------------------------------------
module tb_camera_i2c_arbiter;

  localparam int         MAX_RETRY = 3;
  localparam int         TIMEOUT   = 50;
  localparam logic [7:0] SLAVE     = 8'hBA;
  localparam int         BUDGET    = 600;

  // One engine reply per GO edge.
  typedef struct {
    int delay;
    int hold;
    bit nack;
    bit hang;
  } resp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  camera_i2c_arbiter_if bus();

  camera_i2c_arbiter #(
    .SLAVE_ADDR     (SLAVE),
    .MAX_RETRY      (MAX_RETRY),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TO_W           (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  resp_t       plan[$];
  int          exp_id[$];
  int          exp_err[$];
  int          exp_edges[$];
  int          exp_hang[$];
  logic [31:0] exp_data[$];
  bit          model_last    = 1'b1;
  bit          model_to_flag = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural engine: waits for a GO rising edge, then answers with the
  // next planned reply after 'delay' cycles, holding eng_end for 'hold' cycles.
  initial begin : engine
    resp_t r;
    logic  prev;
    prev         = 1'b0;
    bus.eng_end  = 1'b0;
    bus.eng_nack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.eng_go && !prev) begin
        if (plan.size() > 0) r = plan.pop_front();
        else                 r = '{delay: 3, hold: 1, nack: 1'b0, hang: 1'b0};
        if (!r.hang) begin
          repeat (r.delay) begin @(posedge clock); #1; end
          bus.eng_nack = r.nack;
          bus.eng_end  = 1'b1;
          repeat (r.hold) begin @(posedge clock); #1; end
          bus.eng_end  = 1'b0;
          bus.eng_nack = 1'b0;
        end
      end
      prev = bus.eng_go;
    end
  end

  // Transaction model of one granted transfer.
  // kind 0..MAX_RETRY   : that many NACKs, then ACK
  // kind MAX_RETRY+1    : NACK on every attempt
  // kind 10+k           : k NACKs, then the engine never answers
  task automatic planTransfer(input int id, input logic [23:0] data, input int kind, input int fixed_delay);
    int    nacks;
    resp_t r;
    nacks = (kind >= 10) ? kind - 10 : kind;
    for (int i = 0; i < nacks; i++) begin
      r.delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
      r.hold  = int'($urandom_range(1, 3));
      r.nack  = 1'b1;
      r.hang  = 1'b0;
      plan.push_back(r);
    end
    exp_id.push_back(id);
    exp_data.push_back({SLAVE, data});
    if (kind >= 10) begin
      r = '{delay: 0, hold: 0, nack: 1'b0, hang: 1'b1};
      plan.push_back(r);
      exp_edges.push_back(nacks + 1);
      exp_err.push_back(1);
      exp_hang.push_back(1);
      model_to_flag = 1'b1;
    end else if (nacks > MAX_RETRY) begin
      exp_edges.push_back(nacks);
      exp_err.push_back(1);
      exp_hang.push_back(0);
    end else begin
      r.delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
      r.hold  = int'($urandom_range(1, 3));
      r.nack  = 1'b0;
      r.hang  = 1'b0;
      plan.push_back(r);
      exp_edges.push_back(nacks + 1);
      exp_err.push_back(0);
      exp_hang.push_back(0);
    end
  endtask

  function automatic int randomKind();
    int p;
    p = int'($urandom_range(0, 9));
    if (p == 0) return 10 + int'($urandom_range(0, MAX_RETRY));
    if (p <= 2) return MAX_RETRY + 1;
    return int'($urandom_range(0, MAX_RETRY));
  endfunction

  function automatic void clearModel();
    exp_id.delete();
    exp_err.delete();
    exp_edges.delete();
    exp_hang.delete();
    exp_data.delete();
  endfunction

  // Watches n transfers starting from the cycle the requests are first seen.
  // Requesters drop their req on their own done pulse.
  task automatic runMonitor(input int n);
    int   t           = 0;
    int   served      = 0;
    int   edges       = 0;
    int   first_go    = -1;
    int   go_rise_t   = 0;
    int   end_t       = -1000;
    int   idle_cycles = 0;
    logic go_prev     = 1'b0;
    logic end_prev    = 1'b0;
    logic err;
    while (served < n && t < BUDGET) begin
      @(negedge clock);
      t++;
      if (bus.eng_end && !end_prev) end_t = t;
      end_prev = bus.eng_end;
      if (bus.eng_go && !go_prev) begin
        edges++;
        go_rise_t = t;
        if (first_go < 0) first_go = t;
        checkOutput("eng_data", bus.eng_data, exp_data[served]);
      end
      go_prev = bus.eng_go;
      if (!bus.busy) idle_cycles++;
      if (bus.done0 || bus.done1) begin
        err = bus.done1 ? bus.err1 : bus.err0;
        checkOutput("done_owner", 32'(bus.done1), 32'(exp_id[served]));
        checkOutput("done_both", 32'(bus.done0 & bus.done1), 32'd0);
        checkOutput("err", 32'(err), 32'(exp_err[served]));
        checkOutput("go_edges", 32'(edges), 32'(exp_edges[served]));
        if (exp_hang[served] != 0) checkOutput("timeout_len", 32'(t - go_rise_t), 32'(TIMEOUT));
        else                       checkOutput("end_to_done", 32'(t - end_t), 32'd1);
        if (bus.done1) bus.req1 = 1'b0;
        else           bus.req0 = 1'b0;
        served++;
        edges = 0;
      end
    end
    checkOutput("served", 32'(served), 32'(n));
    checkOutput("go_latency", 32'(first_go), 32'd2);
    checkOutput("idle_between", 32'(idle_cycles), 32'(n - 1));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic idleCheck();
    int extra = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done0 || bus.done1) extra++;
    end
    checkOutput("extra_done", 32'(extra), 32'd0);
    checkOutput("busy_idle", 32'(bus.busy), 32'd0);
    checkOutput("timeout_flag", 32'(bus.timeout_flag), 32'(model_to_flag));
    checkOutput("plan_used", 32'(plan.size()), 32'd0);
    plan.delete();
  endtask

  // Raises the selected requests together and checks the served sequence.
  task automatic applyStimulus(input bit r0, input bit r1, input logic [23:0] d0, input logic [23:0] d1,
                               input int k0, input int k1, input int dly);
    int first;
    int n;
    clearModel();
    if (r0 && r1) begin
      first = model_last ? 0 : 1;
      n     = 2;
    end else begin
      first = r1 ? 1 : 0;
      n     = 1;
    end
    for (int i = 0; i < n; i++) begin
      int id;
      id = (i == 0) ? first : 1 - first;
      planTransfer(id, (id == 1) ? d1 : d0, (id == 1) ? k1 : k0, dly);
      model_last = (id == 1);
    end
    @(negedge clock);
    bus.data0 = d0;
    bus.data1 = d1;
    bus.req0  = r0;
    bus.req1  = r1;
    runMonitor(n);
    idleCheck();
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    resp_t r;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_go", 32'(bus.eng_go), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'({bus.done0, bus.done1, bus.err0, bus.err1}), 32'd0);
    checkOutput("rst_eng_data", bus.eng_data, 32'd0);
    checkOutput("rst_flag", 32'(bus.timeout_flag), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] single write");
    applyStimulus(1'b1, 1'b0, 24'h090400, 24'h000000, 0, 0, 10);

    $display("[TB] contention, three pairs");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom()), 24'($urandom()), 0, 0, 0);

    $display("[TB] nack retry, exhaustion, timeout");
    applyStimulus(1'b0, 1'b1, 24'h12ABCD, 24'h3003E8, 0, 2, 0);
    applyStimulus(1'b1, 1'b0, 24'h4455AA, 24'h000000, MAX_RETRY + 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 24'h000000, 24'h0A0123, 0, 10, 0);
    applyStimulus(1'b1, 1'b0, 24'h0B0042, 24'h000000, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 25; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      applyStimulus(pat[0], pat[1], 24'($urandom()), 24'($urandom()), randomKind(), randomKind(), 0);
    end

    $display("[TB] reset mid-transfer");
    clearModel();
    plan.delete();
    r = '{delay: 0, hold: 0, nack: 1'b0, hang: 1'b1};
    plan.push_back(r);
    @(negedge clock);
    bus.data0 = 24'h3A5C11;
    bus.req0  = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("go_before_reset", 32'(bus.eng_go), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_go", 32'(bus.eng_go), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    checkOutput("mid_rst_flag", 32'(bus.timeout_flag), 32'd0);
    checkOutput("mid_rst_eng_data", bus.eng_data, 32'd0);
    model_last    = 1'b1;
    model_to_flag = 1'b0;
    planTransfer(0, 24'h3A5C11, MAX_RETRY, 0);
    model_last = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    runMonitor(1);
    idleCheck();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/camera_i2c_arbiter.md
Name: camera_i2c_arbiter

Overview:
- Shares one I2C register-write engine between two requesters: requester 0 is the boot-time configuration sequencer, requester 1 is the runtime register updater (exposure, windowing).
- Arbitrates round-robin and frames each 24-bit {sub_addr, data} word with the sensor slave address.
- Retries NACKed transfers and aborts hung ones, then reports completion and error to the requester that was granted.

Parameters:
- SLAVE_ADDR, 8'hBA, sensor I2C write address placed in eng_data[31:24].
- MAX_RETRY, 3, re-issues allowed after a NACK before reporting error (0 = no retry).
- TIMEOUT_CYCLES, 2000000, clock cycles allowed in WAIT before abort.
- TO_W, 24, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; the engine handshake is synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request; held high with data0 stable until done0.
- data0  in  24  requester 0 {sub_addr[7:0], value[15:0]}.
- done0  out  1  one-cycle pulse: requester 0 transfer finished.
- err0  out  1  valid with done0; 1 = failed (NACK after retries, or timeout).
- req1, data1, done1, err1: same as above for requester 1.
- busy  out  1  high in every state except IDLE.
- eng_data  out  32  {SLAVE_ADDR, latched 24-bit word} to the engine.
- eng_go  out  1  start level to the engine; held high until eng_end.
- eng_end  in  1  engine transfer complete, level or pulse.
- eng_nack  in  1  sampled with eng_end; 1 = slave did not acknowledge.
- timeout_flag  out  1  sticky; set on any abort, cleared only by reset.

Behaviour:
- Reset (asynchronous, any state, mid-transfer included):
  - state=IDLE; eng_go=0; eng_data=0; done0/1=0; err0/1=0; busy=0; timeout_flag=0.
  - retry_cnt=0; to_cnt=0; owner=0; last=1, so req0 wins the first tie.
- State IDLE:
  - No request: stay in IDLE.
  - Only reqN high: owner=N.
  - Both high: owner = ~last.
  - On any grant: last<=owner; word<=dataN; retry_cnt<=0; go to ISSUE.
  - Grant is registered: ISSUE is entered the cycle after req is sampled.
- State ISSUE (1 cycle): eng_data<={SLAVE_ADDR, word}; eng_go<=1; to_cnt<=0; go to WAIT.
- State WAIT:
  - to_cnt increments every cycle.
  - eng_end=1 and eng_nack=0: eng_go<=0; result ok; go to DONE.
  - eng_end=1, eng_nack=1, retry_cnt<MAX_RETRY: eng_go<=0; retry_cnt++; go to GAP.
  - eng_end=1, eng_nack=1, retry_cnt==MAX_RETRY: eng_go<=0; result err; go to DONE.
  - to_cnt==TIMEOUT_CYCLES-1 with no eng_end: eng_go<=0; result err; timeout_flag<=1; go to DONE.
  - eng_end and timeout in the same cycle: eng_end wins and its nack/ack result is used.
- State GAP:
  - Holds eng_go=0 until eng_end is sampled low, so the engine sees a fresh GO edge.
  - Then go to ISSUE with the same latched word.
  - The timeout counter is not running in GAP; it restarts in ISSUE.
- State DONE (1 cycle): doneN=1 and errN=result for the owner only; the other done stays 0; go to REL.
- State REL (1 cycle): all requests ignored, so the owner drops req; go to IDLE.
- If reqN is still high in IDLE after REL, it is a new request and is re-arbitrated.
- Requests arriving while busy wait; no request is lost or dropped.
- Deassertion of req during a transfer is ignored; the transfer completes and done still pulses.
- Latency, grant sample to eng_go high: 2 cycles.
- Latency, successful eng_end to done: 1 cycle.
- Minimum back-to-back spacing between two grants: 2 cycles after done (REL, then IDLE sample).
- eng_data is stable from ISSUE until the next ISSUE.

Test Plan:
- Single write: req0, data0=24'h09_0400, engine acks 10 cycles after go -> eng_data=32'hBA090400; eng_go high 2 cycles after req; done0=1 and err0=0 exactly one cycle after eng_end; done1 never pulses.
- Contention: req0 and req1 asserted in the same cycle, both held -> requester 0 served first, then requester 1; with a third simultaneous pair, requester 0 is served again (alternation); busy stays low only in IDLE.
- NACK retry: MAX_RETRY=3, engine NACKs twice then acks -> exactly 3 rising edges on eng_go with identical eng_data; each rising edge is preceded by a cycle with eng_go=0; done1 with err1=0.
- NACK exhaustion: engine always NACKs -> 4 go edges, then done with err=1; timeout_flag stays 0.
- Timeout: TIMEOUT_CYCLES=50, engine never ends -> eng_go drops on the cycle to_cnt reaches 49; done with err=1; timeout_flag=1 and stays set; a following request still proceeds normally.
- Reset mid-transfer: assert reset_n=0 in WAIT -> eng_go=0, busy=0, done0/1=0 asynchronously; after release, a pending req0 is served from IDLE with retry_cnt=0.
